load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the core's memory stage and the data memory block. Accepts one RV32I load/store request at a time and drives the word-wide `memRead`/`memWrite`/`address`/`writeData` bus of the data memory. Returns sign- or zero-extended load data. Sub-word stores are built by read-modify-write, because the RAM only writes whole 32-bit words.

## Interface

Parameters:
- `IO_BASE`, 32'hFFFF0000: first MMIO address; addresses at or above it are I/O.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on a clock edge where `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle pulse when the request completes.
- `rsp_rdata`  out  32  extended load data, valid with `rsp_valid`; 0 for stores.
- `rsp_err`  out  1  valid with `rsp_valid`; flags an illegal funct3 or a trapped misalignment.
- `mem_read`  out  1  to data memory `memRead`.
- `mem_write`  out  1  to data memory `memWrite`.
- `mem_addr`  out  32  to data memory `address`; always word-aligned ({addr[31:2],2'b00}).
- `mem_wdata`  out  32  to data memory `writeData`.
- `mem_rdata`  in  32  from data memory `readData`.

## Operation

- **Request capture.** On acceptance, the address, funct3, we and wdata are registered. The block ignores `req_*` until it returns to IDLE.
- **States:** IDLE, RD_ADDR, RD_DATA, WR, RESP.
- **Transitions:**
  - Load: IDLE → RD_ADDR → RD_DATA → RESP → IDLE.
  - SW, or any store to the I/O region: IDLE → WR → RESP.
  - SB/SH to RAM: IDLE → RD_ADDR → RD_DATA → WR → RESP.
  - Error: IDLE → RESP with `rsp_err`=1 and no memory strobes.
- **Read phase.** `mem_read`=1 and `mem_addr` are held for both RD_ADDR and RD_DATA. `mem_rdata` is sampled at the end of RD_DATA. This covers the RAM's registered output and the combinational I/O path with one uniform latency.
- **Load extraction:**
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Store merge.**
  - RAM: the selected byte or halfword of the captured word is replaced with the low bits of wdata.
  - I/O sub-word store: no read phase; data is shifted into its lane and the other lanes are 0.
- **Write pulse.** `mem_write`=1 for exactly one cycle (WR).
- **Illegal funct3.** Illegal values are 011, 110 and 111 for loads, and 1xx for stores. The block responds with `rsp_err`=1 and `rsp_rdata`=0.
- **Output encoding.** All memory-side outputs are decoded from registered state and data, with no combinational path from `req_*`.

## Timing

- **Latency** (acceptance edge → `rsp_valid` cycle):
  - Load: 3 cycles.
  - SW or I/O store: 2 cycles.
  - RAM SB/SH: 4 cycles.
  - Error: 1 cycle.
- **Throughput.** `req_ready` reasserts in the cycle after RESP, so back-to-back requests are separated by at least one IDLE cycle.
- **Reset values:** state=IDLE; `req_ready`=1; `rsp_valid`, `rsp_err`, `mem_read`, `mem_write`=0; `rsp_rdata`, `mem_addr`, `mem_wdata`=0.
- **Reset mid-operation.** Outputs clear immediately (async). A sub-word store reset before WR never writes memory. No response is issued for the aborted request.
- **Mid-request input changes.** `req_valid` falling or `req_*` changing mid-request have no effect.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]≠0, goes directly to RESP with `rsp_err`=1.
  - No strobes are driven.
- Not defined:
  - Low address bits are forced to natural alignment (halfword clears addr[0]; word clears addr[1:0]).
  - The access then proceeds normally and `rsp_err` flags only illegal funct3.

## Structure

- **`lsu_pkg`:** state enum, funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), `IO_BASE` default.
- **`lsu_align`** (combinational sub-module): load extraction/extension and store lane merge.
- **`load_store_unit`:** holds the FSM and request registers.

## Test plan

- SW 0x00000010 ← 0xDEADBEEF, then LW 0x00000010:
  - Store: one `mem_write` cycle with `mem_wdata`=0xDEADBEEF.
  - Load: `rsp_rdata`=0xDEADBEEF, 3 cycles after acceptance.
- SB 0x00000011 ← 0x000000AA over 0xDEADBEEF:
  - Write is 0xDEADAAEF.
  - LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA.
- SH 0x00000012 ← 0x00008001:
  - Word becomes 0x8001AAEF.
  - LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
- I/O with input_port=0x0000005A:
  - LW 0xFFFF0000 → 0x5A, 3-cycle latency.
  - SB 0xFFFF0004 ← 0x7F: `mem_read` never asserts; `mem_wdata`=0x0000007F.
- LW 0x00000012 and funct3=011 load:
  - With the macro: `rsp_err`=1, no strobes.
  - Without the macro: LW reads word 0x00000010.
  - funct3=011 gives `rsp_err`=1 in both builds.
- `rst` pulsed during RD_DATA of SB 0x11:
  - `mem_write` never asserts and the memory word is unchanged.
  - After release: `req_ready`=1, `rsp_valid`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and helpers for the load/store unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see load_store_unit.sv).
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] LSU_IO_BASE = 32'hFFFF0000;

  // Loads accept 000/001/010/100/101; stores reject anything with bit 2 set.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3[2];
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Access width from funct3[1:0]: 00 byte, 01 halfword, otherwise word.
  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic is_word(input logic [2:0] f3);
    return f3[1];
  endfunction

  // Force the low address bits to the natural alignment of the access.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] a;
    a = addr;
    if (is_word(f3)) a[1:0] = 2'b00;
    else if (is_half(f3)) a[0] = 1'b0;
    return a;
  endfunction

  // True when the access is not naturally aligned.
  function automatic logic misaligned(input logic [31:0] addr, input logic [2:0] f3);
    if (is_word(f3)) return addr[1:0] != 2'b00;
    if (is_half(f3)) return addr[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load lane extraction/extension and store lane merge.
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] load_word,
  input  logic [31:0] store_base,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte/halfword and extend it according to funct3.
  always_comb begin
    sel_byte  = load_word[{lane, 3'b000} +: 8];
    sel_half  = lane[1] ? load_word[31:16] : load_word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = '0;
    endcase
  end

  // Overlay the low store data bits onto the base word in the addressed lane.
  always_comb begin
    store_word = store_base;
    case (funct3[1:0])
      2'b00:   store_word[{lane, 3'b000} +: 8] = store_data[7:0];
      2'b01:   store_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32I load/store onto a word-wide data memory bus.
// Sub-word RAM stores use read-modify-write; I/O stores are written directly.
// Optional: LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead
// of forcing natural alignment.
module load_store_unit import lsu_pkg::*; #(
  parameter logic [31:0] IO_BASE = LSU_IO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_next;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [2:0]  f3_q;
  logic        we_q, err_q;

  logic        accept;
  logic        req_misalign;
  logic        req_err;
  logic        req_io;
  logic        io_q;
  logic [31:0] load_ext;
  logic [31:0] store_merged;

  assign accept = req_valid && (state == ST_IDLE);
  assign req_io = req_addr >= IO_BASE;
  assign io_q   = addr_q >= IO_BASE;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misalign = misaligned(req_addr, req_funct3);
`else
  assign req_misalign = 1'b0;
`endif

  assign req_err = f3_illegal(req_we, req_funct3) || req_misalign;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state: word and I/O stores skip the read phase, errors go straight to RESP.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                             state_next = ST_RESP;
          else if (req_we && (is_word(req_funct3) || req_io)) state_next = ST_WR;
          else                                     state_next = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: state_next = ST_RD_DATA;
      ST_RD_DATA: state_next = we_q ? ST_WR : ST_RESP;
      ST_WR:      state_next = ST_RESP;
      ST_RESP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Request capture on acceptance and memory word capture at the end of RD_DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= align_addr(req_addr, req_funct3);
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        we_q    <= req_we;
        err_q   <= req_err;
      end
      if (state == ST_RD_DATA) word_q <= mem_rdata;
    end
  end

  // I/O sub-word stores have no read phase, so their other lanes are zero.
  lsu_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .load_word  (word_q),
    .store_base (io_q ? 32'h0 : word_q),
    .store_data (wdata_q),
    .load_data  (load_ext),
    .store_word (store_merged)
  );

  // Bus and response outputs decoded from registered state and data only.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_RD_ADDR, ST_RD_DATA: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
      end
      ST_WR: begin
        mem_write = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = store_merged;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'h0 : load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench with a small RAM + I/O model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  // Memory model: 64-word RAM with registered read, plus a combinational input port.
  logic [31:0] ram [0:63] = '{default: 32'h0};
  logic [31:0] rd_reg = 32'h0;
  logic [31:0] input_port = 32'h0000005A;
  int          wr_total = 0, rd_total = 0, rsp_total = 0;
  logic [31:0] last_wdata = 32'h0, last_waddr = 32'h0, last_raddr = 32'h0;

  assign mem_rdata = (mem_addr >= 32'hFFFF0000) ? input_port : rd_reg;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM behaviour on the clock edge.
  always @(posedge clk) begin
    if (mem_read && mem_addr < 32'hFFFF0000) rd_reg <= ram[mem_addr[7:2]];
    if (mem_write && mem_addr < 32'hFFFF0000) ram[mem_addr[7:2]] <= mem_wdata;
  end

  // Strobe monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write) begin
      wr_total   <= wr_total + 1;
      last_wdata <= mem_wdata;
      last_waddr <= mem_addr;
    end
    if (mem_read) begin
      rd_total   <= rd_total + 1;
      last_raddr <= mem_addr;
    end
    if (rsp_valid) rsp_total <= rsp_total + 1;
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int lat, output int nwr, output int nrd);
    int wr0, rd0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL req_ready_idle got=%b exp=1", req_ready);
    end
    wr0 = wr_total;
    rd0 = rd_total;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = ~addr; req_wdata = ~wdata;
    lat = -1; rdata = 32'hX; err = 1'bX;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = i; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    #1;
    nwr = wr_total - wr0;
    nrd = rd_total - rd0;
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=10000", {req_ready, rsp_valid, rsp_err, mem_read, mem_write});
    end
    checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=0", {rsp_rdata, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat, nw, nr;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, nw, nr);
    checks++;
    if (lat !== 2 || nw !== 1 || nr !== 0 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL sw_timing got lat=%0d wr=%0d rd=%0d err=%b rdata=%h exp 2/1/0/0/0", lat, nw, nr, er, rd);
    end
    checks++;
    if (last_wdata !== 32'hDEADBEEF || last_waddr !== 32'h10) begin
      failures++;
      $display("[TB] FAIL sw_bus got=%h@%h exp=deadbeef@00000010", last_wdata, last_waddr);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'hDEADBEEF || lat !== 3 || nr !== 2 || nw !== 0 || er !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lw got rdata=%h lat=%0d rd=%0d wr=%0d err=%b exp deadbeef/3/2/0/0", rd, lat, nr, nw, er);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int lat, nw, nr;
    do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, rd, er, lat, nw, nr);
    checks++;
    if (last_wdata !== 32'hDEADAAEF || lat !== 4 || nw !== 1 || nr !== 2) begin
      failures++;
      $display("[TB] FAIL sb got wdata=%h lat=%0d wr=%0d rd=%0d exp deadaaef/4/1/2", last_wdata, lat, nw, nr);
    end
    do_req(1'b0, 3'b000, 32'h11, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'hFFFFFFAA) begin
      failures++;
      $display("[TB] FAIL lb got=%h exp=ffffffaa", rd);
    end
    do_req(1'b0, 3'b100, 32'h11, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'h000000AA) begin
      failures++;
      $display("[TB] FAIL lbu got=%h exp=000000aa", rd);
    end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er; int lat, nw, nr;
    do_req(1'b1, 3'b001, 32'h12, 32'h00008001, rd, er, lat, nw, nr);
    checks++;
    if (last_wdata !== 32'h8001AAEF || lat !== 4) begin
      failures++;
      $display("[TB] FAIL sh got wdata=%h lat=%0d exp 8001aaef/4", last_wdata, lat);
    end
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'hFFFF8001) begin
      failures++;
      $display("[TB] FAIL lh got=%h exp=ffff8001", rd);
    end
    do_req(1'b0, 3'b101, 32'h12, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'h00008001) begin
      failures++;
      $display("[TB] FAIL lhu got=%h exp=00008001", rd);
    end
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'hFFFFFF80) begin
      failures++;
      $display("[TB] FAIL lb_lane3 got=%h exp=ffffff80", rd);
    end
    do_req(1'b0, 3'b100, 32'h10, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'h000000EF) begin
      failures++;
      $display("[TB] FAIL lbu_lane0 got=%h exp=000000ef", rd);
    end
  endtask

  task automatic test_io;
    logic [31:0] rd; logic er; int lat, nw, nr;
    do_req(1'b0, 3'b010, 32'hFFFF0000, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'h0000005A || lat !== 3) begin
      failures++;
      $display("[TB] FAIL io_lw got rdata=%h lat=%0d exp 0000005a/3", rd, lat);
    end
    do_req(1'b1, 3'b000, 32'hFFFF0004, 32'h0000007F, rd, er, lat, nw, nr);
    checks++;
    if (nr !== 0 || nw !== 1 || lat !== 2 || last_wdata !== 32'h0000007F || last_waddr !== 32'hFFFF0004) begin
      failures++;
      $display("[TB] FAIL io_sb got rd=%0d wr=%0d lat=%0d wdata=%h addr=%h exp 0/1/2/0000007f/ffff0004",
               nr, nw, lat, last_wdata, last_waddr);
    end
    do_req(1'b1, 3'b001, 32'hFFFF0006, 32'h12341234, rd, er, lat, nw, nr);
    checks++;
    if (nr !== 0 || last_wdata !== 32'h12340000 || last_waddr !== 32'hFFFF0004) begin
      failures++;
      $display("[TB] FAIL io_sh got rd=%0d wdata=%h addr=%h exp 0/12340000/ffff0004", nr, last_wdata, last_waddr);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat, nw, nr;
    do_req(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat, nw, nr);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (er !== 1'b1 || lat !== 1 || nr !== 0 || nw !== 0 || rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL lw_misalign got err=%b lat=%0d rd=%0d wr=%0d rdata=%h exp 1/1/0/0/0", er, lat, nr, nw, rd);
    end
`else
    checks++;
    if (er !== 1'b0 || rd !== 32'h8001AAEF || last_raddr !== 32'h10) begin
      failures++;
      $display("[TB] FAIL lw_misalign got err=%b rdata=%h raddr=%h exp 0/8001aaef/00000010", er, rd, last_raddr);
    end
`endif
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (er !== 1'b1 || lat !== 1 || nr !== 0 || nw !== 0 || rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL ld_f3_011 got err=%b lat=%0d rd=%0d wr=%0d rdata=%h exp 1/1/0/0/0", er, lat, nr, nw, rd);
    end
    do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, rd, er, lat, nw, nr);
    checks++;
    if (er !== 1'b1 || lat !== 1 || nw !== 0 || ram[4] !== 32'h8001AAEF) begin
      failures++;
      $display("[TB] FAIL st_f3_100 got err=%b lat=%0d wr=%0d word=%h exp 1/1/0/8001aaef", er, lat, nw, ram[4]);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat, nw, nr, wr0, rsp0;
    @(negedge clk);
    wr0 = wr_total;
    rsp0 = rsp_total;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_in_read got mem_read=%b exp=1", mem_read);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rst_mid_async got read=%b ready=%b addr=%h exp 0/1/0", mem_read, req_ready, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || wr_total !== wr0 || rsp_total !== rsp0 || ram[4] !== 32'h8001AAEF) begin
      failures++;
      $display("[TB] FAIL rst_mid_after got ready=%b rsp=%b writes=%0d rsps=%0d word=%h exp 1/0/0/0/8001aaef",
               req_ready, rsp_valid, wr_total - wr0, rsp_total - rsp0, ram[4]);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nw, nr);
    checks++;
    if (rd !== 32'h8001AAEF || er !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_reload got=%h err=%b exp 8001aaef/0", rd, er);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_word;
    test_byte;
    test_half;
    test_io;
    test_errors;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule
